// File: rtl/editor_config.sv
// Clock/date and timer field editor: cursor-driven increment/decrement of
// time fields with a write-request handshake towards an RTC writer.
module editor_config #(
  parameter int unsigned DIA_MAX  = 31,
  parameter int unsigned ANIO_MAX = 99
) (
  input  logic       clk,
  input  logic       btn_reset,
  input  logic       dism,
  input  logic       aument,
  input  logic       derec,
  input  logic       izqda,
  input  logic       escrib,
  input  logic       sw_CT,
  input  logic       sw_conf,
  input  logic       DOCE_24,
  input  logic       wr_ack,
  output logic [4:0] hora,
  output logic [5:0] min,
  output logic [5:0] seg,
  output logic [4:0] dia,
  output logic [3:0] mes,
  output logic [6:0] anio,
  output logic [4:0] t_hora,
  output logic [5:0] t_min,
  output logic [5:0] t_seg,
  output logic [4:0] hora_disp,
  output logic       pm,
  output logic [2:0] cursor,
  output logic       editando,
  output logic       wr_req,
  output logic       wr_sel
);

  typedef enum logic [1:0] {IDLE, EDIT, WREQ} state_t;

  state_t     state, state_next;
  logic       esc_q, ct_q;
  logic       esc_rise, ct_chg, mv, val;
  logic       in_edit, do_wr, do_ct, do_mv, do_val;
  logic [2:0] cur_max;
  logic [6:0] sel_v, sel_lo, sel_hi, step_v;
  logic [4:0] h12;

  function automatic logic [6:0] wrap_step(input logic [6:0] v, input logic [6:0] lo,
                                           input logic [6:0] hi, input logic up);
    if (up) return (v >= hi) ? lo : v + 7'd1;
    else    return (v <= lo) ? hi : v - 7'd1;
  endfunction

  assign esc_rise = escrib & ~esc_q;
  assign ct_chg   = sw_CT ^ ct_q;
  assign mv       = derec ^ izqda;
  assign val      = aument ^ dism;
  assign in_edit  = (state == EDIT) && sw_conf;
  assign do_wr    = in_edit && esc_rise;
  assign do_ct    = in_edit && !esc_rise && ct_chg;
  assign do_mv    = in_edit && !esc_rise && !ct_chg && mv;
  assign do_val   = in_edit && !esc_rise && !ct_chg && !mv && val;
  assign cur_max  = sw_CT ? 3'd2 : 3'd5;

  always_ff @(posedge clk) begin
    if (btn_reset) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (sw_conf) state_next = EDIT;
      EDIT: begin
        if (!sw_conf)     state_next = IDLE;
        else if (esc_rise) state_next = WREQ;
      end
      WREQ: if (wr_ack) state_next = sw_conf ? EDIT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    editando  = (state == EDIT);
    wr_req    = (state == WREQ);
    pm        = (hora >= 5'd12);
    h12       = pm ? hora - 5'd12 : hora;
    hora_disp = DOCE_24 ? ((h12 == 5'd0) ? 5'd12 : h12) : hora;
  end

  always_comb begin
    sel_v  = '0;
    sel_lo = '0;
    sel_hi = '0;
    case ({sw_CT, cursor})
      4'b0000: begin sel_v = {2'b00, hora};   sel_hi = 7'd23; end
      4'b0001: begin sel_v = {1'b0, min};     sel_hi = 7'd59; end
      4'b0010: begin sel_v = {1'b0, seg};     sel_hi = 7'd59; end
      4'b0011: begin sel_v = {2'b00, dia};    sel_lo = 7'd1; sel_hi = 7'(DIA_MAX); end
      4'b0100: begin sel_v = {3'b000, mes};   sel_lo = 7'd1; sel_hi = 7'd12; end
      4'b0101: begin sel_v = anio;            sel_hi = 7'(ANIO_MAX); end
      4'b1000: begin sel_v = {2'b00, t_hora}; sel_hi = 7'd23; end
      4'b1001: begin sel_v = {1'b0, t_min};   sel_hi = 7'd59; end
      4'b1010: begin sel_v = {1'b0, t_seg};   sel_hi = 7'd59; end
      default: ;
    endcase
    step_v = wrap_step(sel_v, sel_lo, sel_hi, aument);
  end

  // Bank history is frozen during WREQ so a bank flip made while waiting
  // still clears the cursor on the first cycle back in EDIT.
  always_ff @(posedge clk) begin
    if (btn_reset) begin
      cursor <= '0;
      wr_sel <= 1'b0;
      esc_q  <= 1'b0;
      ct_q   <= 1'b0;
    end else begin
      esc_q <= escrib;
      if (state != WREQ) ct_q <= sw_CT;
      if (state == IDLE && sw_conf) cursor <= '0;
      else if (do_ct)               cursor <= '0;
      else if (do_mv) begin
        if (derec) cursor <= (cursor >= cur_max) ? 3'd0 : cursor + 3'd1;
        else       cursor <= (cursor == 3'd0 || cursor > cur_max) ? cur_max : cursor - 3'd1;
      end
      if (do_wr) wr_sel <= sw_CT;
    end
  end

  always_ff @(posedge clk) begin
    if (btn_reset) begin
      hora   <= '0;
      min    <= '0;
      seg    <= '0;
      dia    <= 5'd1;
      mes    <= 4'd1;
      anio   <= '0;
      t_hora <= '0;
      t_min  <= '0;
      t_seg  <= '0;
    end else if (do_val) begin
      case ({sw_CT, cursor})
        4'b0000: hora   <= step_v[4:0];
        4'b0001: min    <= step_v[5:0];
        4'b0010: seg    <= step_v[5:0];
        4'b0011: dia    <= step_v[4:0];
        4'b0100: mes    <= step_v[3:0];
        4'b0101: anio   <= step_v;
        4'b1000: t_hora <= step_v[4:0];
        4'b1001: t_min  <= step_v[5:0];
        4'b1010: t_seg  <= step_v[5:0];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_editor_config.sv
// Scoreboard bench for editor_config: a behavioural model predicts every
// post-edge output snapshot, a monitor compares it against the DUT.
module tb_editor_config;

  localparam int unsigned DIA_MAX  = 31;
  localparam int unsigned ANIO_MAX = 99;

  logic clk = 1'b0;
  logic btn_reset, dism, aument, derec, izqda, escrib, sw_CT, sw_conf, DOCE_24, wr_ack;
  logic [4:0] hora, dia, t_hora, hora_disp;
  logic [5:0] min, seg, t_min, t_seg;
  logic [3:0] mes;
  logic [6:0] anio;
  logic [2:0] cursor;
  logic pm, editando, wr_req, wr_sel;

  always #5 clk = ~clk;

  editor_config #(.DIA_MAX(DIA_MAX), .ANIO_MAX(ANIO_MAX)) dut (
    .clk(clk), .btn_reset(btn_reset), .dism(dism), .aument(aument), .derec(derec),
    .izqda(izqda), .escrib(escrib), .sw_CT(sw_CT), .sw_conf(sw_conf), .DOCE_24(DOCE_24),
    .wr_ack(wr_ack), .hora(hora), .min(min), .seg(seg), .dia(dia), .mes(mes), .anio(anio),
    .t_hora(t_hora), .t_min(t_min), .t_seg(t_seg), .hora_disp(hora_disp), .pm(pm),
    .cursor(cursor), .editando(editando), .wr_req(wr_req), .wr_sel(wr_sel)
  );

  typedef struct {
    int h, mi, s, dd, mo, y, th, tm, ts;
    int cur, ed, rq, sl, disp, pm;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Field order: hora min seg dia mes anio t_hora t_min t_seg
  int lo_t[9] = '{0, 0, 0, 1, 1, 0, 0, 0, 0};
  int hi_t[9] = '{23, 59, 59, int'(DIA_MAX), 12, int'(ANIO_MAX), 23, 59, 59};

  int m_f[9];
  int m_cur;
  bit m_edit, m_wait, m_sel, m_prev_esc, m_prev_ct;
  bit l_conf, l_ct, l_esc, l_doce;

  task automatic model_reset();
    for (int i = 0; i < 9; i++) m_f[i] = lo_t[i];
    m_cur = 0; m_edit = 0; m_wait = 0; m_sel = 0; m_prev_esc = 0; m_prev_ct = 0;
  endtask

  task automatic model_step(input bit rst, input bit a, input bit d, input bit r,
                            input bit l, input bit ack);
    bit was_wait;
    int n, idx, span;
    was_wait = m_wait;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_wait) begin
      if (ack) begin m_wait = 0; m_edit = l_conf; end
    end else if (m_edit) begin
      if (!l_conf) m_edit = 0;
      else if (l_esc && !m_prev_esc) begin m_edit = 0; m_wait = 1; m_sel = l_ct; end
      else if (l_ct != m_prev_ct) m_cur = 0;
      else if (r != l) begin
        n = l_ct ? 3 : 6;
        m_cur = r ? (m_cur + 1) % n : (m_cur + n - 1) % n;
      end else if (a != d) begin
        idx  = l_ct ? 6 + m_cur : m_cur;
        span = hi_t[idx] - lo_t[idx] + 1;
        m_f[idx] = lo_t[idx] + (m_f[idx] - lo_t[idx] + (a ? 1 : span - 1)) % span;
      end
    end else if (l_conf) begin
      m_edit = 1; m_cur = 0;
    end
    m_prev_esc = l_esc;
    if (!was_wait) m_prev_ct = l_ct;
  endtask

  task automatic tick(input bit rst, input bit a, input bit d, input bit r,
                      input bit l, input bit ack);
    exp_t e;
    int h12;
    @(negedge clk);
    btn_reset = rst; aument = a; dism = d; derec = r; izqda = l; wr_ack = ack;
    sw_conf = l_conf; sw_CT = l_ct; escrib = l_esc; DOCE_24 = l_doce;
    model_step(rst, a, d, r, l, ack);
    e.h = m_f[0]; e.mi = m_f[1]; e.s = m_f[2]; e.dd = m_f[3]; e.mo = m_f[4];
    e.y = m_f[5]; e.th = m_f[6]; e.tm = m_f[7]; e.ts = m_f[8];
    e.cur = m_cur; e.ed = m_edit; e.rq = m_wait; e.sl = m_sel;
    e.pm = (m_f[0] >= 12);
    h12 = m_f[0] % 12;
    e.disp = l_doce ? ((h12 == 0) ? 12 : h12) : m_f[0];
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp_v, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("hora", int'(hora), e.h);
        chk("min", int'(min), e.mi);
        chk("seg", int'(seg), e.s);
        chk("dia", int'(dia), e.dd);
        chk("mes", int'(mes), e.mo);
        chk("anio", int'(anio), e.y);
        chk("t_hora", int'(t_hora), e.th);
        chk("t_min", int'(t_min), e.tm);
        chk("t_seg", int'(t_seg), e.ts);
        chk("cursor", int'(cursor), e.cur);
        chk("editando", int'(editando), e.ed);
        chk("wr_req", int'(wr_req), e.rq);
        chk("wr_sel", int'(wr_sel), e.sl);
        chk("pm", int'(pm), e.pm);
        chk("hora_disp", int'(hora_disp), e.disp);
      end
    end
  end

  initial begin : stimulus
    bit rst, a, d, r, l, ack;
    btn_reset = 1'b1; aument = 0; dism = 0; derec = 0; izqda = 0; wr_ack = 0;
    sw_conf = 0; sw_CT = 0; escrib = 0; DOCE_24 = 0;
    l_conf = 0; l_ct = 0; l_esc = 0; l_doce = 0;
    model_reset();

    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 1, 0, 0);                       // pulses in IDLE do nothing
    l_conf = 1;
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1, 0);                       // cursor 0 -> 5
    repeat (ANIO_MAX + 1) tick(0, 1, 0, 0, 0, 0); // anio wraps to 0
    tick(0, 0, 0, 1, 0, 0);                       // cursor 5 -> 0
    tick(0, 0, 1, 0, 0, 0);                       // hora 0 -> 23
    tick(0, 1, 0, 0, 0, 0);                       // hora 23 -> 0
    l_doce = 1;
    repeat (11) tick(0, 0, 1, 0, 0, 0);           // hora 13, 12 h display
    repeat (11) tick(0, 1, 0, 0, 0, 0);           // hora 0 -> shown as 12
    tick(0, 0, 0, 1, 1, 0);
    tick(0, 1, 1, 0, 0, 0);
    repeat (3) tick(0, 0, 0, 1, 0, 0);            // cursor on dia
    tick(0, 0, 1, 0, 0, 0);                       // dia 1 -> DIA_MAX
    tick(0, 0, 0, 1, 0, 0);
    tick(0, 0, 1, 0, 0, 0);                       // mes 1 -> 12
    tick(0, 1, 0, 0, 0, 0);                       // mes 12 -> 1
    l_ct = 1;
    tick(0, 1, 0, 0, 0, 0);                       // bank change wins over aument
    l_esc = 1;
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0);
    tick(0, 1, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0, 1);
    l_esc = 0;
    tick(0, 1, 0, 0, 0, 0);
    l_esc = 1;
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);                       // reset mid-handshake
    l_conf = 0;
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 1);
    l_esc = 0;

    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) l_conf = ~l_conf;
      if ($urandom_range(0, 39) == 0) l_ct = ~l_ct;
      if ($urandom_range(0, 5) == 0) l_esc = ~l_esc;
      if ($urandom_range(0, 29) == 0) l_doce = ~l_doce;
      a   = ($urandom_range(0, 2) == 0);
      d   = ($urandom_range(0, 3) == 0);
      r   = ($urandom_range(0, 4) == 0);
      l   = ($urandom_range(0, 5) == 0);
      ack = ($urandom_range(0, 4) == 0);
      tick(rst, a, d, r, l, ack);
    end

    @(negedge clk);
    aument = 0; dism = 0; derec = 0; izqda = 0; wr_ack = 0; btn_reset = 0;
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
